// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and width limits for the gray counter family.
package gray_pkg;

    localparam int unsigned MAX_W = 32;

    // Binary to reflected Gray code; upper unused bits of b must be zero.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary over the low w bits; bits at or above w are ignored.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g,
                                                  input int unsigned w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] gm;
        logic [MAX_W-1:0] b;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        gm   = g & mask;
        b    = gm;
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = gm[i] ^ b[i+1];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_enc.sv
// Parametrised combinational binary-to-Gray encoder.
module gray_enc
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = WIDTH'(bin2gray(MAX_W'(bin)));

endmodule

// File: rtl/gray_counter.sv
// Up/down loadable counter with registered binary, Gray code, wrap pulse
// and a mask of the Gray bits that toggled on the last update.
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned INIT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             wrap,
    output logic [WIDTH-1:0] chg
);

    localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] INIT_GRAY = WIDTH'(bin2gray(MAX_W'(INIT_BIN)));

    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_gray;
    logic             next_wrap;

    // Next-state selection: load beats count, count beats hold.
    always_comb begin
        next_bin  = bin;
        next_wrap = 1'b0;
        if (load) begin
            next_bin = load_bin;
        end else if (en) begin
            if (up) begin
                next_bin  = bin + WIDTH'(1);
                next_wrap = (bin == '1);
            end else begin
                next_bin  = bin - WIDTH'(1);
                next_wrap = (bin == '0);
            end
        end
    end

    // Encode before the flop so gray is a register, not decoded from bin.
    gray_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .bin  (next_bin),
        .gray (next_gray)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= INIT_BIN;
            gray <= INIT_GRAY;
            wrap <= 1'b0;
            chg  <= '0;
        end else begin
            bin  <= next_bin;
            gray <= next_gray;
            wrap <= next_wrap;
            chg  <= gray ^ next_gray;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: two instances (4-bit INIT=0, 8-bit INIT=FE)
// checked every cycle against an arithmetic model plus literal expectations.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       clk_on = 1'b0;
    logic       rst_n;

    logic       en_a, up_a, load_a;
    logic [3:0] lb_a;
    logic [3:0] gray_a, bin_a, chg_a;
    logic       wrap_a;

    logic       en_b, up_b, load_b;
    logic [7:0] lb_b;
    logic [7:0] gray_b, bin_b, chg_b;
    logic       wrap_b;

    int errors = 0;
    int checks = 0;

    gray_counter #(.WIDTH(4), .INIT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .up(up_a), .load(load_a),
        .load_bin(lb_a), .gray(gray_a), .bin(bin_a), .wrap(wrap_a), .chg(chg_a)
    );

    gray_counter #(.WIDTH(8), .INIT(32'hFE)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .up(up_b), .load(load_b),
        .load_bin(lb_b), .gray(gray_b), .bin(bin_b), .wrap(wrap_b), .chg(chg_b)
    );

    always begin
        #5;
        if (clk_on) clk = ~clk;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain modular arithmetic on integers.
    function automatic longint gcode(input longint v);
        return v ^ (v >> 1);
    endfunction

    function automatic longint nxt_bin(input int w, input longint b, input bit ld,
                                       input longint lb, input bit e, input bit u);
        longint m = longint'(1) << w;
        if (ld) return lb;
        if (!e) return b;
        return ((u ? b + 1 : b - 1) + m) % m;
    endfunction

    function automatic bit nxt_wrap(input int w, input longint b, input bit ld,
                                    input bit e, input bit u);
        longint t;
        if (ld || !e) return 1'b0;
        t = u ? b + 1 : b - 1;
        return (t < 0) || (t >= (longint'(1) << w));
    endfunction

    longint ma_b, ma_g, ma_c, mb_b, mb_g, mb_c;
    bit     ma_w, mb_w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_b <= 0;   ma_g <= 0;           ma_w <= 1'b0; ma_c <= 0;
            mb_b <= 254; mb_g <= gcode(254);  mb_w <= 1'b0; mb_c <= 0;
        end else begin
            ma_b <= nxt_bin(4, ma_b, load_a, longint'(lb_a), en_a, up_a);
            ma_g <= gcode(nxt_bin(4, ma_b, load_a, longint'(lb_a), en_a, up_a));
            ma_w <= nxt_wrap(4, ma_b, load_a, en_a, up_a);
            ma_c <= ma_g ^ gcode(nxt_bin(4, ma_b, load_a, longint'(lb_a), en_a, up_a));
            mb_b <= nxt_bin(8, mb_b, load_b, longint'(lb_b), en_b, up_b);
            mb_g <= gcode(nxt_bin(8, mb_b, load_b, longint'(lb_b), en_b, up_b));
            mb_w <= nxt_wrap(8, mb_b, load_b, en_b, up_b);
            mb_c <= mb_g ^ gcode(nxt_bin(8, mb_b, load_b, longint'(lb_b), en_b, up_b));
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("a_bin",  longint'(bin_a),  ma_b);
        chk("a_gray", longint'(gray_a), ma_g);
        chk("a_wrap", longint'(wrap_a), longint'(ma_w));
        chk("a_chg",  longint'(chg_a),  ma_c);
        chk("b_bin",  longint'(bin_b),  mb_b);
        chk("b_gray", longint'(gray_b), mb_g);
        chk("b_wrap", longint'(wrap_b), longint'(mb_w));
        chk("b_chg",  longint'(chg_b),  mb_c);
        chk("b_invariant", longint'(gray_b), longint'(bin_b ^ (bin_b >> 1)));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_a(input string nm, input longint b, input longint g,
                         input longint w, input longint c);
        chk({nm, "_bin"},  longint'(bin_a),  b);
        chk({nm, "_gray"}, longint'(gray_a), g);
        chk({nm, "_wrap"}, longint'(wrap_a), w);
        chk({nm, "_chg"},  longint'(chg_a),  c);
    endtask

    int seq [0:16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    initial begin
        rst_n = 1'b1;
        en_a = 1'b0; up_a = 1'b1; load_a = 1'b0; lb_a = '0;
        en_b = 1'b1; up_b = 1'b1; load_b = 1'b0; lb_b = '0;
        #1 rst_n = 1'b0;
        #2;
        // Reset values with the clock stopped.
        chk_a("rst", 0, 0, 0, 0);
        chk("rst_b_bin",  longint'(bin_b),  'hFE);
        chk("rst_b_gray", longint'(gray_b), 'h81);
        chk("rst_b_wrap", longint'(wrap_b), 0);
        chk("rst_b_chg",  longint'(chg_b),  0);
        clk_on = 1'b1;
        tick();
        rst_n = 1'b1;
        en_a  = 1'b1;
        up_a  = 1'b1;

        // Full up sweep with wrap on the last step.
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("sweep_gray", longint'(gray_a), longint'(seq[i]));
            chk("sweep_onehot", longint'($onehot(chg_a)), 1);
            if (i == 2) begin
                chk("w8_bin",  longint'(bin_b),  0);
                chk("w8_gray", longint'(gray_b), 0);
                chk("w8_wrap", longint'(wrap_b), 1);
                chk("w8_chg",  longint'(chg_b),  'h80);
            end
            if (i < 16) chk("sweep_nowrap", longint'(wrap_a), 0);
        end
        chk_a("sweep_end", 0, 0, 1, 'h8);

        up_a = 1'b0;
        tick();
        chk_a("down_wrap", 'hF, 'h8, 1, 'h8);

        load_a = 1'b1; lb_a = 4'b0101;
        tick();
        chk_a("load5", 'h5, 'h7, 0, 'h7 ^ 'h8);

        up_a = 1'b1; lb_a = 4'b1001;
        tick();
        chk_a("load_prio", 'h9, 'hD, 0, 'hA);

        tick();
        chk_a("load_same", 'h9, 'hD, 0, 0);

        load_a = 1'b0; en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_a("hold", 'h9, 'hD, 0, 0);
        end

        load_a = 1'b1; lb_a = 4'b0111;
        tick();
        chk_a("load7", 'h7, 'h4, 0, 'hD ^ 'h4);

        // Reset mid-count, between edges, with an increment pending.
        load_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_a("midrst", 0, 0, 0, 0);
        chk("midrst_b_bin", longint'(bin_b), 'hFE);
        tick();
        chk_a("rst_held", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_a("first_edge", 1, 1, 0, 1);

        up_a = 1'b0;
        tick();
        tick();
        chk_a("down_again", 'hF, 'h8, 1, 'h8);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-002 Parameter WIDTH, default 4: counter and code width in bits; legal range 2..32.
REQ-003 Parameter INIT, default 0: binary reset value; must fit in WIDTH bits.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 en  in  1  count enable.
REQ-007 up  in  1  direction; 1 = increment, 0 = decrement.
REQ-008 load  in  1  synchronous load strobe.
REQ-009 load_bin  in  WIDTH  binary value loaded when load=1.
REQ-010 gray  out  WIDTH  registered Gray code of the current count.
REQ-011 bin  out  WIDTH  registered binary count.
REQ-012 wrap  out  1  one-cycle pulse when the count wraps.
REQ-013 chg  out  WIDTH  registered mask of the gray bits that changed on the last update.

Function
REQ-014 All outputs shall be driven directly from flops, with no combinational path from any input to any output.
REQ-015 Invariant: gray == bin ^ (bin >> 1) in every cycle, including the reset state.
REQ-016 Latency: an input sampled at rising edge N shall be visible on the outputs after edge N.
REQ-017 Priority is load > en > hold.
  - load=1: bin <= load_bin; gray <= its Gray code; wrap <= 0; chg <= old gray ^ new gray. up and en are ignored.
REQ-018 en=1, up=1, load=0: bin <= (bin + 1) mod 2^WIDTH.
  - wrap <= 1 only when the old bin is all ones.
REQ-019 en=1, up=0, load=0: bin <= (bin - 1) mod 2^WIDTH.
  - wrap <= 1 only when the old bin is zero.
REQ-020 On every count step, chg shall be one-hot and equal old gray ^ new gray.
  - Exactly one gray bit toggles, including across the wrap.
REQ-021 Hold (en=0, load=0): bin and gray keep their values; wrap <= 0; chg <= 0.
REQ-022 wrap shall never stay high for two consecutive cycles unless a wrap occurs on consecutive enabled steps.
  - Example: WIDTH=2 toggling direction at the boundary.
REQ-023 Loading the current value shall give chg = 0 and wrap = 0.
REQ-024 Arithmetic is unsigned and modulo 2^WIDTH; there is no saturation mode.

Reset
REQ-025 While rst_n=0, independent of clk:
  - bin = INIT; gray = Gray(INIT); wrap = 0; chg = 0.
REQ-026 Assertion of rst_n mid-count shall abandon the in-progress update immediately.
REQ-027 After deassertion, the first rising edge with rst_n=1 shall be the first edge to act on load/en.

Structure
REQ-028 Shared package gray_pkg shall hold:
  - the bin2gray and gray2bin functions, parametrised by width;
  - localparam MAX_W = 32.
REQ-029 One sub-module, gray_enc, shall be a parametrised combinational binary-to-Gray encoder.
  - Instantiated once on the next-state path so that gray is registered, not derived from bin after the flop.
REQ-030 No other sub-modules are allowed; the next-state logic and registers live in gray_counter.

Verification
REQ-031 The bench shall cover the following scenarios. Values are for WIDTH=4, INIT=0 unless stated.
  - Reset: rst_n=0 with no clock -> bin=0000, gray=0000, wrap=0, chg=0000.
  - Up sweep: en=1, up=1 for 16 cycles from 0 ->
    - gray follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000;
    - the final step gives wrap=1 and chg=1000;
    - every step gives one-hot chg.
  - Down wrap: from 0, en=1, up=0 for one cycle -> bin=1111, gray=1000, wrap=1, chg=1000.
  - Load priority: bin=0101 (gray 0111), then load=1, load_bin=1001, en=1, up=1 -> bin=1001, gray=1101, wrap=0, chg=1010.
  - Hold, then mid-count reset:
    - en=0 for 5 cycles -> outputs unchanged, chg=0000, wrap=0;
    - at bin=0111, drive rst_n=0 between edges -> outputs return to INIT before the next edge.
  - Width/INIT sweep: WIDTH=8, INIT=8'hFE, en=1, up=1 ->
    - after 2 edges bin=00, gray=00, wrap=1, chg=8'h80;
    - the invariant gray == bin ^ (bin >> 1) is checked every cycle.
